trail_unwind: RTL and testbench

Backtrack stage that sits directly downstream of the conflict analysis engine (`cae`). On `start` it takes the CAE's `backtrack_level`, learned-clause id and asserting (first-UIP) literal. It then pops every trail entry whose level exceeds `backtrack_level`, one per cycle, newest first, and issues an unassign for each popped variable to the variable table. Finally it pushes the asserting literal onto the trail as an implied assignment at `backtrack_level`, with the learned clause as its reason.

---
 rtl/trail_unwind_if.sv | 58 +++++
 rtl/trail_unwind.sv | 121 ++++++++++++
 tb/tb_trail_unwind.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/trail_unwind_if.sv
// rtl/trail_unwind_if.sv - request, trail-port and result bundle for trail_unwind
//
// Purpose: groups the signals of the backtrack stage into one bundle.
//   master : conflict-analysis side plus trail owner (drives the request and
//            the trail read data, observes pops/unassigns/pushes/status)
//   slave  : the trail_unwind block itself
// Signals:
//   start, backtrack_level, asserting_lit, learned_clause_id, trail_height : request
//   trail_read_idx / trail_read_var / trail_read_level                     : trail read port
//   trail_pop, unassign_valid, unassign_var                                : unwind actions
//   push_valid, push_var, push_value, push_level, push_reason              : implied push
//   busy, done, popped_count, level_out                                    : status
interface trail_unwind_if #(
  parameter int LEVEL_W = 16,
  parameter int TRAIL_W = 16,
  parameter int VAR_W   = 32
);
  logic                start;
  logic [LEVEL_W-1:0]  backtrack_level;
  logic signed [31:0]  asserting_lit;
  logic [15:0]         learned_clause_id;
  logic [TRAIL_W-1:0]  trail_height;

  logic [TRAIL_W-1:0]  trail_read_idx;
  logic [VAR_W-1:0]    trail_read_var;
  logic [LEVEL_W-1:0]  trail_read_level;

  logic                trail_pop;
  logic                unassign_valid;
  logic [VAR_W-1:0]    unassign_var;

  logic                push_valid;
  logic [VAR_W-1:0]    push_var;
  logic                push_value;
  logic [LEVEL_W-1:0]  push_level;
  logic [15:0]         push_reason;

  logic                busy;
  logic                done;
  logic [TRAIL_W-1:0]  popped_count;
  logic [LEVEL_W-1:0]  level_out;

  modport master (
    output start, backtrack_level, asserting_lit, learned_clause_id, trail_height,
    output trail_read_var, trail_read_level,
    input  trail_read_idx, trail_pop, unassign_valid, unassign_var,
    input  push_valid, push_var, push_value, push_level, push_reason,
    input  busy, done, popped_count, level_out
  );

  modport slave (
    input  start, backtrack_level, asserting_lit, learned_clause_id, trail_height,
    input  trail_read_var, trail_read_level,
    output trail_read_idx, trail_pop, unassign_valid, unassign_var,
    output push_valid, push_var, push_value, push_level, push_reason,
    output busy, done, popped_count, level_out
  );
endinterface

// File: rtl/trail_unwind.sv
// rtl/trail_unwind.sv - backtrack stage: pop trail above target level, then push asserting literal
//
// Purpose: on start, pops every trail entry whose level exceeds the target
//   level (newest first, one per cycle), unassigning each popped variable,
//   then pushes the asserting literal as an implied assignment at the target
//   level with the learned clause as reason.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : trail_unwind_if.slave (request, trail read port, actions, status)
module trail_unwind #(
  parameter int LEVEL_W = 16,
  parameter int TRAIL_W = 16,
  parameter int VAR_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  trail_unwind_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNWIND = 2'd1,
    S_ASSERT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [TRAIL_W-1:0]  ptr;
  logic [LEVEL_W-1:0]  level_q;
  logic [31:0]         lit_q;
  logic [15:0]         reason_q;
  logic [TRAIL_W-1:0]  popped_q;
  logic [LEVEL_W-1:0]  level_out_q;

  logic                do_pop;
  logic                do_push;
  logic [TRAIL_W-1:0]  read_idx;
  logic [31:0]         lit_mag;

  // Two's-complement magnitude; the most negative literal maps to 2^31,
  // which still fits the unsigned 32-bit result.
  assign lit_mag = lit_q[31] ? (~lit_q + 32'd1) : lit_q;

  always_comb begin
    state_nx = state;
    do_pop   = 1'b0;
    do_push  = 1'b0;
    read_idx = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_UNWIND;
      end
      S_UNWIND: begin
        // Never address ptr-1 when ptr is 0: the read would wrap to the top.
        if (ptr != '0) begin
          read_idx = ptr - TRAIL_W'(1);
          do_pop   = (bus.trail_read_level > level_q);
        end
        // The trail is level-monotone, so the first entry at or below the
        // target level ends the unwind.
        if (!do_pop) state_nx = S_ASSERT;
      end
      S_ASSERT: begin
        do_push  = (lit_q != 32'd0);
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      level_q     <= '0;
      lit_q       <= '0;
      reason_q    <= '0;
      popped_q    <= '0;
      level_out_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.start) begin
        level_q  <= bus.backtrack_level;
        lit_q    <= bus.asserting_lit;
        reason_q <= bus.learned_clause_id;
        ptr      <= bus.trail_height;
        popped_q <= '0;
      end
      if (do_pop) begin
        ptr      <= ptr - TRAIL_W'(1);
        popped_q <= popped_q + TRAIL_W'(1);
      end
      if (state == S_DONE) level_out_q <= level_q;
    end
  end

  assign bus.trail_read_idx = read_idx;
  assign bus.trail_pop      = do_pop;
  assign bus.unassign_valid = do_pop;
  assign bus.unassign_var   = do_pop ? bus.trail_read_var : '0;

  // Push fields are held at zero outside the push cycle so that idle and
  // reset present an all-zero interface.
  assign bus.push_valid  = do_push;
  assign bus.push_var    = do_push ? VAR_W'(lit_mag) : '0;
  assign bus.push_value  = do_push & ~lit_q[31];
  assign bus.push_level  = do_push ? level_q : '0;
  assign bus.push_reason = do_push ? reason_q : '0;

  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_DONE);
  assign bus.popped_count = popped_q;
  assign bus.level_out    = level_out_q;

endmodule

// File: tb/tb_trail_unwind.sv
// tb/tb_trail_unwind.sv - directed self-checking bench for trail_unwind
module tb_trail_unwind;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  trail_unwind_if #(.LEVEL_W(16), .TRAIL_W(16), .VAR_W(32)) bus ();

  trail_unwind #(.LEVEL_W(16), .TRAIL_W(16), .VAR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mem_var [16];
  int mem_lev [16];

  always_comb begin
    if (bus.trail_read_idx < 16) begin
      bus.trail_read_var   = 32'(mem_var[bus.trail_read_idx]);
      bus.trail_read_level = 16'(mem_lev[bus.trail_read_idx]);
    end else begin
      bus.trail_read_var   = '0;
      bus.trail_read_level = '0;
    end
  end

  int pop_idx[$];
  int pop_var[$];
  int pop_cyc[$];
  int push_n, push_cyc, push_var_s, push_val_s, push_lvl_s, push_rsn_s;
  int done_n, done_cyc, popped_s, lvl_out_s;
  bit busy_c1, busy_after, wrap_seen;

  task automatic run_op(input int h, input int bt, input int lit, input int id, input bit repulse);
    pop_idx.delete(); pop_var.delete(); pop_cyc.delete();
    push_n = 0; push_cyc = 0; push_var_s = 0; push_val_s = 0; push_lvl_s = 0; push_rsn_s = 0;
    done_n = 0; done_cyc = 0; popped_s = -1; lvl_out_s = -1;
    busy_c1 = 0; busy_after = 1; wrap_seen = 0;
    @(negedge clk);
    bus.trail_height = 16'(h); bus.backtrack_level = 16'(bt);
    bus.asserting_lit = lit; bus.learned_clause_id = 16'(id);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (repulse && c == 2) begin
        bus.start = 1'b1; bus.backtrack_level = 16'd0; bus.asserting_lit = 9;
        bus.trail_height = 16'd3; bus.learned_clause_id = 16'd99;
      end
      if (repulse && c == 3) bus.start = 1'b0;
      if (c == 1) busy_c1 = bus.busy;
      if (bus.trail_read_idx == 16'hFFFF) wrap_seen = 1;
      if (bus.trail_pop) begin
        pop_idx.push_back(int'(bus.trail_read_idx));
        pop_var.push_back(int'(bus.unassign_var));
        pop_cyc.push_back(c);
      end
      if (bus.push_valid) begin
        push_n++; push_cyc = c; push_var_s = int'(bus.push_var);
        push_val_s = int'(bus.push_value); push_lvl_s = int'(bus.push_level);
        push_rsn_s = int'(bus.push_reason);
      end
      if (done_cyc != 0 && c == done_cyc + 1) begin
        busy_after = bus.busy; popped_s = int'(bus.popped_count); lvl_out_s = int'(bus.level_out);
        break;
      end
      if (bus.done) begin done_n++; done_cyc = c; end
    end
  endtask

  task automatic load_trail();
    int v[6] = '{4, 5, 6, 1, 2, 3};
    int l[6] = '{2, 3, 5, 5, 5, 5};
    for (int i = 0; i < 16; i++) begin mem_var[i] = 0; mem_lev[i] = 0; end
    for (int i = 0; i < 6; i++) begin mem_var[i] = v[i]; mem_lev[i] = l[i]; end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.trail_read_idx !== 16'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", bus.trail_read_idx); end
    checks++; if (bus.push_value !== 1'b0 || bus.push_valid !== 1'b0 || bus.push_var !== 32'd0) begin errors++; $display("FAIL rst_push: got v=%0b val=%0b var=%0d want 0", bus.push_valid, bus.push_value, bus.push_var); end
    checks++; if (bus.trail_pop !== 1'b0 || bus.unassign_valid !== 1'b0 || bus.unassign_var !== 32'd0) begin errors++; $display("FAIL rst_pop: got %0b/%0b/%0d want 0", bus.trail_pop, bus.unassign_valid, bus.unassign_var); end
    checks++; if (bus.done !== 1'b0 || bus.popped_count !== 16'd0 || bus.level_out !== 16'd0) begin errors++; $display("FAIL rst_status: got done=%0b pc=%0d lo=%0d want 0", bus.done, bus.popped_count, bus.level_out); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_deep_unwind();
    int ei[4] = '{5, 4, 3, 2};
    int ev[4] = '{3, 2, 1, 6};
    run_op(6, 3, -2, 200, 0);
    checks++; if (pop_idx.size() !== 4) begin errors++; $display("FAIL deep_npops: got %0d want 4", pop_idx.size()); end
    for (int i = 0; i < 4 && i < pop_idx.size(); i++) begin
      checks++; if (pop_idx[i] !== ei[i] || pop_var[i] !== ev[i] || pop_cyc[i] !== i + 1) begin errors++; $display("FAIL deep_pop%0d: got idx=%0d var=%0d cyc=%0d want %0d %0d %0d", i, pop_idx[i], pop_var[i], pop_cyc[i], ei[i], ev[i], i + 1); end
    end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL deep_busy_c1: got %0b want 1", busy_c1); end
    checks++; if (push_n !== 1 || push_cyc !== 6) begin errors++; $display("FAIL deep_push_cyc: got n=%0d cyc=%0d want 1 6", push_n, push_cyc); end
    checks++; if (push_var_s !== 2 || push_val_s !== 0 || push_lvl_s !== 3 || push_rsn_s !== 200) begin errors++; $display("FAIL deep_push_fields: got %0d %0d %0d %0d want 2 0 3 200", push_var_s, push_val_s, push_lvl_s, push_rsn_s); end
    checks++; if (done_n !== 1 || done_cyc !== 7) begin errors++; $display("FAIL deep_done: got n=%0d cyc=%0d want 1 7", done_n, done_cyc); end
    checks++; if (popped_s !== 4 || lvl_out_s !== 3 || busy_after !== 1'b0) begin errors++; $display("FAIL deep_status: got pc=%0d lo=%0d busy=%0b want 4 3 0", popped_s, lvl_out_s, busy_after); end
  endtask

  task automatic test_noop_unwind();
    run_op(6, 5, 7, 12, 0);
    checks++; if (pop_idx.size() !== 0) begin errors++; $display("FAIL noop_npops: got %0d want 0", pop_idx.size()); end
    checks++; if (push_n !== 1 || push_cyc !== 2 || push_var_s !== 7 || push_val_s !== 1 || push_lvl_s !== 5 || push_rsn_s !== 12) begin errors++; $display("FAIL noop_push: got n=%0d cyc=%0d %0d %0d %0d %0d want 1 2 7 1 5 12", push_n, push_cyc, push_var_s, push_val_s, push_lvl_s, push_rsn_s); end
    checks++; if (done_cyc !== 3 || popped_s !== 0 || lvl_out_s !== 5) begin errors++; $display("FAIL noop_done: got cyc=%0d pc=%0d lo=%0d want 3 0 5", done_cyc, popped_s, lvl_out_s); end
  endtask

  task automatic test_full_unwind();
    run_op(6, 0, -6, 77, 0);
    checks++; if (pop_idx.size() !== 6) begin errors++; $display("FAIL root_npops: got %0d want 6", pop_idx.size()); end
    checks++; if (pop_idx.size() == 6 && (pop_idx[5] !== 0 || pop_var[5] !== 4)) begin errors++; $display("FAIL root_last_pop: got idx=%0d var=%0d want 0 4", pop_idx[5], pop_var[5]); end
    checks++; if (wrap_seen !== 1'b0) begin errors++; $display("FAIL root_wrap: got %0b want 0", wrap_seen); end
    checks++; if (push_cyc !== 8 || push_lvl_s !== 0 || push_var_s !== 6 || push_val_s !== 0) begin errors++; $display("FAIL root_push: got cyc=%0d lvl=%0d var=%0d val=%0d want 8 0 6 0", push_cyc, push_lvl_s, push_var_s, push_val_s); end
    checks++; if (done_cyc !== 9 || popped_s !== 6 || lvl_out_s !== 0) begin errors++; $display("FAIL root_done: got cyc=%0d pc=%0d lo=%0d want 9 6 0", done_cyc, popped_s, lvl_out_s); end
  endtask

  task automatic test_empty_trail();
    run_op(0, 0, 1, 5, 0);
    checks++; if (pop_idx.size() !== 0 || wrap_seen !== 1'b0) begin errors++; $display("FAIL empty_pops: got n=%0d wrap=%0b want 0 0", pop_idx.size(), wrap_seen); end
    checks++; if (push_n !== 1 || push_var_s !== 1 || push_val_s !== 1 || push_cyc !== 2) begin errors++; $display("FAIL empty_push: got n=%0d var=%0d val=%0d cyc=%0d want 1 1 1 2", push_n, push_var_s, push_val_s, push_cyc); end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL empty_done: got %0d want 3", done_cyc); end
  endtask

  task automatic test_zero_literal();
    run_op(6, 3, 0, 44, 0);
    checks++; if (pop_idx.size() !== 4) begin errors++; $display("FAIL zero_npops: got %0d want 4", pop_idx.size()); end
    checks++; if (push_n !== 0) begin errors++; $display("FAIL zero_push: got %0d pushes want 0", push_n); end
    checks++; if (done_cyc !== 7 || popped_s !== 4) begin errors++; $display("FAIL zero_done: got cyc=%0d pc=%0d want 7 4", done_cyc, popped_s); end
  endtask

  task automatic test_start_repulse();
    int ev[4] = '{3, 2, 1, 6};
    run_op(6, 3, -2, 200, 1);
    checks++; if (pop_idx.size() !== 4) begin errors++; $display("FAIL repulse_npops: got %0d want 4", pop_idx.size()); end
    for (int i = 0; i < 4 && i < pop_var.size(); i++) begin
      checks++; if (pop_var[i] !== ev[i] || pop_cyc[i] !== i + 1) begin errors++; $display("FAIL repulse_pop%0d: got var=%0d cyc=%0d want %0d %0d", i, pop_var[i], pop_cyc[i], ev[i], i + 1); end
    end
    checks++; if (push_cyc !== 6 || push_var_s !== 2 || push_val_s !== 0 || push_lvl_s !== 3 || push_rsn_s !== 200) begin errors++; $display("FAIL repulse_push: got cyc=%0d %0d %0d %0d %0d want 6 2 0 3 200", push_cyc, push_var_s, push_val_s, push_lvl_s, push_rsn_s); end
    checks++; if (done_cyc !== 7 || popped_s !== 4 || lvl_out_s !== 3) begin errors++; $display("FAIL repulse_done: got cyc=%0d pc=%0d lo=%0d want 7 4 3", done_cyc, popped_s, lvl_out_s); end
  endtask

  task automatic test_reset_abort();
    int pops = 0;
    int late = 0;
    @(negedge clk);
    bus.trail_height = 16'd6; bus.backtrack_level = 16'd3;
    bus.asserting_lit = -2; bus.learned_clause_id = 16'd200;
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.trail_pop) pops++;
    end
    checks++; if (pops !== 2) begin errors++; $display("FAIL abort_prepops: got %0d want 2", pops); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.trail_pop !== 1'b0 || bus.unassign_valid !== 1'b0 || bus.unassign_var !== 32'd0 || bus.trail_read_idx !== 16'd0) begin errors++; $display("FAIL abort_outputs: got busy=%0b pop=%0b uv=%0b var=%0d idx=%0d want 0", bus.busy, bus.trail_pop, bus.unassign_valid, bus.unassign_var, bus.trail_read_idx); end
    checks++; if (bus.push_valid !== 1'b0 || bus.done !== 1'b0 || bus.popped_count !== 16'd0 || bus.level_out !== 16'd0) begin errors++; $display("FAIL abort_status: got pv=%0b done=%0b pc=%0d lo=%0d want 0", bus.push_valid, bus.done, bus.popped_count, bus.level_out); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.push_valid || bus.trail_pop || bus.busy) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", late); end
    run_op(6, 5, 7, 12, 0);
    checks++; if (pop_idx.size() !== 0 || push_cyc !== 2 || push_var_s !== 7 || done_cyc !== 3 || lvl_out_s !== 5) begin errors++; $display("FAIL abort_rerun: got pops=%0d pcyc=%0d var=%0d dcyc=%0d lo=%0d want 0 2 7 3 5", pop_idx.size(), push_cyc, push_var_s, done_cyc, lvl_out_s); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.backtrack_level = '0;
    bus.asserting_lit = 0;
    bus.learned_clause_id = '0;
    bus.trail_height = '0;
    load_trail();
    test_reset();
    test_deep_unwind();
    test_noop_unwind();
    test_full_unwind();
    test_empty_trail();
    test_zero_literal();
    test_start_repulse();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
